// File: rtl/seg7_pkg.sv
// Shared 7-segment types, segment encodings and the nibble decode function.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'b0000000;

    // Segment order {a,b,c,d,e,f,g}, indexed by nibble value 0..F
    localparam seg7_t SEG7_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic seg7_t seg7_decode(input logic [3:0] nibble, input logic hex_mode);
        if (!hex_mode && (nibble > 4'd9)) begin
            return SEG_OFF;
        end
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder shared with the single-digit path.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output seg7_t      seg_c
);

    assign seg_c = seg7_decode(nibble, hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-aligned updates.
// Optional leading-zero suppression when SEG7_LZS_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    hex_mode,
    output seg7_t                   seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam seg7_t       SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [NUM_DIGITS-1:0][3:0] shadow_data;
    logic [NUM_DIGITS-1:0][3:0] active_data;
    logic [NUM_DIGITS-1:0]      shadow_blank;
    logic [NUM_DIGITS-1:0]      active_blank;
    logic [NUM_DIGITS-1:0]      supp_mask;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           idx;

    logic                       cnt_wrap_c;
    logic                       frame_wrap_c;
    logic [3:0]                 nibble_c;
    seg7_t                      dec_seg_c;
    seg7_t                      seg_next_c;
    logic [NUM_DIGITS-1:0]      en_next_c;

    assign cnt_wrap_c   = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_wrap_c = cnt_wrap_c && (idx == IDX_W'(NUM_DIGITS - 1));
    assign nibble_c     = active_data[idx];

    seg7_decoder u_decoder (
        .nibble   (nibble_c),
        .hex_mode (hex_mode),
        .seg_c    (dec_seg_c)
    );

`ifdef SEG7_LZS_EN
    // Suppression mask follows the value entering the active register at the frame boundary
    localparam logic [NUM_DIGITS-1:0] SUPP_RST = {{(NUM_DIGITS - 1){1'b1}}, 1'b0};

    logic [NUM_DIGITS-1:0] supp_next_c;
    logic                  lead_c;

    always_comb begin
        supp_next_c = '0;
        lead_c      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead_c && (shadow_data[i] == 4'd0)) begin
                supp_next_c[i] = 1'b1;
            end else begin
                lead_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            supp_mask <= SUPP_RST;
        end else if (frame_wrap_c) begin
            supp_mask <= supp_next_c;
        end
    end
`else
    assign supp_mask = '0;
`endif

    // Next output values; digit_en is held off on the first cycle of each slot
    always_comb begin
        en_next_c  = '0;
        seg_next_c = dec_seg_c;
        if (cnt != '0) begin
            en_next_c = NUM_DIGITS'(1) << idx;
        end
        if (active_blank[idx] || supp_mask[idx]) begin
            seg_next_c = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            active_data  <= '0;
            active_blank <= '0;
            seg_out      <= SEG_OFF ^ SEG_POL;
            digit_en     <= '0;
            frame_done   <= 1'b0;
        end else begin
            cnt        <= cnt_wrap_c ? '0 : cnt + CNT_W'(1);
            frame_done <= frame_wrap_c;
            seg_out    <= seg_next_c ^ SEG_POL;
            digit_en   <= en_next_c;
            if (cnt_wrap_c) begin
                idx <= frame_wrap_c ? '0 : idx + IDX_W'(1);
            end
            // Active takes the pre-load shadow when load lands on the boundary
            if (frame_wrap_c) begin
                active_data  <= shadow_data;
                active_blank <= shadow_blank;
            end
            if (load) begin
                shadow_data  <= data_in;
                shadow_blank <= blank_in;
            end
        end
    end

endmodule
